// File: rtl/parking_gate_sequencer.sv
// parking_gate_sequencer
//   Multi-lane gate sequencer on the 1 ms tick. Each lane turns a button press
//   and a direction into a timed gate state code. A shared arbiter passes one
//   save request per tick to the record-save unit, lowest lane index first.
// Ports:
//   ms, rst_n          tick clock, async active-low reset
//   i_press[N_CH]      per-lane button level (already synchronised)
//   i_is_out[N_CH]     per-lane direction, 1 = exit, 0 = entry
//   o_state[3*N_CH]    per-lane state code, lane i at [3i+2:3i]
//   o_busy[N_CH]       lane in ENTER, EXIT or EXIT_DONE
//   o_save_valid       one-tick save grant strobe
//   o_save_ch[3]       granted lane index (0 when no grant)
//   o_activate_save    one-hot copy of the grant

// One gate lane: hold counter, latched direction, state code.
module parking_gate_lane #(
    parameter int HOLD_MS = 2000,
    parameter int DONE_MS = 0,
    parameter int CNT_W   = 11
) (
    input  logic       ms,
    input  logic       rst_n,
    input  logic       i_press,
    input  logic       i_is_out,
    output logic [2:0] o_state,
    output logic       o_busy,
    output logic       o_req
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTER = 3'd1,
        S_EXIT  = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MS);
    localparam logic [CNT_W-1:0] DONE_C = CNT_W'(DONE_MS);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dcnt;
    logic             r_dir;
    logic             r_press_q;

    always_ff @(posedge ms or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_dcnt    <= '0;
            r_dir     <= 1'b0;
            r_press_q <= 1'b0;
        end else begin
            r_press_q <= i_press;
            if (i_press) begin
                r_cnt <= HOLD_C;
                // direction is taken at the press edge only
                if (!r_press_q) r_dir <= i_is_out;
                if (r_state > S_DONE) r_state <= S_IDLE;
            end else if (r_cnt != '0) begin
                r_state <= r_dir ? S_EXIT : S_ENTER;
                r_cnt   <= r_cnt - 1'b1;
            end else begin
                case (r_state)
                    S_IDLE:  r_state <= S_IDLE;
                    S_ENTER: r_state <= S_IDLE;
                    S_EXIT: begin
                        r_state <= S_DONE;
                        r_dcnt  <= DONE_C;
                    end
                    S_DONE: begin
                        if (r_dcnt != '0) r_dcnt  <= r_dcnt - 1'b1;
                        else              r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_state = r_state;
    assign o_busy  = (r_state == S_ENTER) || (r_state == S_EXIT) || (r_state == S_DONE);
    // window completes on the edge that takes the counter from 1 to 0
    assign o_req   = !i_press && (r_cnt == CNT_W'(1));
endmodule

module parking_gate_sequencer #(
    parameter int N_CH    = 2,
    parameter int HOLD_MS = 2000,
    parameter int DONE_MS = 0,
    parameter int CNT_W   = 11
) (
    input  logic              ms,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   i_press,
    input  logic [N_CH-1:0]   i_is_out,
    output logic [3*N_CH-1:0] o_state,
    output logic [N_CH-1:0]   o_busy,
    output logic              o_save_valid,
    output logic [2:0]        o_save_ch,
    output logic [N_CH-1:0]   o_activate_save
);
    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_clr;
    logic [2:0]      w_idx;
    logic            w_any;
    logic [N_CH-1:0] r_pending;
    logic            r_save_valid;
    logic [2:0]      r_save_ch;
    logic [N_CH-1:0] r_act;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        parking_gate_lane #(
            .HOLD_MS (HOLD_MS),
            .DONE_MS (DONE_MS),
            .CNT_W   (CNT_W)
        ) u_lane (
            .ms       (ms),
            .rst_n    (rst_n),
            .i_press  (i_press[g]),
            .i_is_out (i_is_out[g]),
            .o_state  (o_state[3*g +: 3]),
            .o_busy   (o_busy[g]),
            .o_req    (w_req[g])
        );
    end

    // fixed priority: lowest pending lane wins
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_pending[i] && !w_any) begin
                w_any    = 1'b1;
                w_idx    = 3'(i);
                w_clr[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge ms or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= '0;
            r_save_valid <= 1'b0;
            r_save_ch    <= '0;
            r_act        <= '0;
        end else begin
            // a new request on the grant edge survives the clear
            r_pending    <= (r_pending & ~w_clr) | w_req;
            r_save_valid <= w_any;
            r_save_ch    <= w_idx;
            r_act        <= w_clr;
        end
    end

    assign o_save_valid    = r_save_valid;
    assign o_save_ch       = r_save_ch;
    assign o_activate_save = r_act;
endmodule
